// File: rtl/dyt_sram_ctrl_if.sv
// Request/response channel of the SRAM controller.
// The slave side is the memory; the master side issues requests and sinks responses.
interface dyt_sram_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_wen;
    logic [31:0]               req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_be;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;
    logic                      init_done;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/dyt_sram_ctrl.sv
// Single-port SRAM with byte-enable writes, a fixed-latency read pipeline,
// out-of-range error responses and an optional post-reset clear sweep.
module dyt_sram_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter int unsigned BYTE_ADDR      = 1
) (
    input logic             clk,
    input logic             n_rst,
    dyt_sram_ctrl_if.slave  bus
);
    localparam int unsigned NB       = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS = $clog2(NB);
    localparam int unsigned AW       = $clog2(DEPTH);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e                 state_q;
    logic [AW-1:0]          clr_cnt_q;
    logic                   req_ready_q;
    logic                   init_done_q;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic                   vld_q  [READ_LATENCY];
    logic [DATA_WIDTH-1:0]  data_q [READ_LATENCY];
    logic                   err_q  [READ_LATENCY];

    logic [31:0]            word_idx;
    logic                   in_range;
    logic                   wr_fire;
    logic                   rd_fire;
    logic [DATA_WIDTH-1:0]  rd_word;

    // Full 32-bit index compare so out-of-range addresses never alias onto real words.
    assign word_idx = (BYTE_ADDR != 0) ? (bus.req_addr >> OFF_BITS) : bus.req_addr;
    assign in_range = (word_idx < 32'(DEPTH));
    assign wr_fire  = bus.req_valid & req_ready_q & bus.req_wen & in_range;
    assign rd_fire  = bus.req_valid & req_ready_q & ~bus.req_wen;

    // Array read for the request presented this cycle; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem_q[word_idx[AW-1:0]];
        end
    end

    // Control FSM: clear sweep after reset, then accept requests until the next reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            if (CLEAR_ON_RESET != 0) begin
                state_q <= StInit;
            end else begin
                state_q <= StReady;
            end
            clr_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == AW'(DEPTH - 1)) begin
                        state_q     <= StReady;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                StReady: begin
                    req_ready_q <= 1'b1;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q <= StReady;
                end
            endcase
        end
    end

    // Storage: the clear sweep and accepted writes are mutually exclusive since
    // req_ready is low for the whole sweep. Contents are not reset.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            if (state_q == StInit) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wr_fire) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.req_be[b]) begin
                        mem_q[word_idx[AW-1:0]][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read pipeline: data/err only advance with a valid, so the last stage holds
    // the most recent response between strobes.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i]  <= 1'b0;
                data_q[i] <= '0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            vld_q[0] <= rd_fire;
            if (rd_fire) begin
                data_q[0] <= rd_word;
                err_q[0]  <= ~in_range;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                    err_q[i]  <= err_q[i-1];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.init_done = init_done_q;
    assign bus.rsp_valid = vld_q[READ_LATENCY-1];
    assign bus.rsp_rdata = data_q[READ_LATENCY-1];
    assign bus.rsp_err   = err_q[READ_LATENCY-1];
endmodule

// File: tb/tb_dyt_sram_ctrl.sv
// Directed bench: three controllers (READ_LATENCY 1, 2, 3) share one request
// stream so every response can be checked against its own latency.
module tb_dyt_sram_ctrl;
    logic        clk;
    logic        n_rst;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        rdy   [3];
    logic        idone [3];
    logic        rv    [3];
    logic [31:0] rd    [3];
    logic        re    [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dyt_sram_ctrl_if #(.DATA_WIDTH(32)) bus ();

        assign bus.req_valid = req_valid;
        assign bus.req_wen   = req_wen;
        assign bus.req_addr  = req_addr;
        assign bus.req_wdata = req_wdata;
        assign bus.req_be    = req_be;

        dyt_sram_ctrl #(
            .DATA_WIDTH     (32),
            .DEPTH          (64),
            .READ_LATENCY   (g + 1),
            .CLEAR_ON_RESET (1),
            .BYTE_ADDR      (1)
        ) u_dut (
            .clk   (clk),
            .n_rst (n_rst),
            .bus   (bus)
        );

        assign rdy[g]   = bus.req_ready;
        assign idone[g] = bus.init_done;
        assign rv[g]    = bus.rsp_valid;
        assign rd[g]    = bus.rsp_rdata;
        assign re[g]    = bus.rsp_err;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        step();
        req_valid = 1'b0;
        req_wen   = 1'b0;
    endtask

    // Single read; dut d must strobe exactly on the (d+1)-th cycle after accept.
    task automatic read_one(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = addr;
        for (int c = 0; c < 4; c++) begin
            step();
            req_valid = 1'b0;
            for (int d = 0; d < 3; d++) begin
                check($sformatf("%s.L%0d.c%0d.valid", tag, d + 1, c), 32'(rv[d]),
                      32'(d == c));
                if (d == c) begin
                    check($sformatf("%s.L%0d.rdata", tag, d + 1), rd[d], exp_data);
                    check($sformatf("%s.L%0d.err", tag, d + 1), 32'(re[d]), 32'(exp_err));
                end
            end
        end
    endtask

    // Counts cycles with req_ready low after reset release; watches for stray
    // responses from the latency-2/3 instances.
    task automatic measure_init(input string tag, inout logic saw_rsp);
        int cnt;
        cnt = 0;
        n_rst = 1'b1;
        while (rdy[0] !== 1'b1 && cnt < 200) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("%s.L%0d.init_done_low", tag, d + 1), 32'(idone[d]), 32'd0);
            end
            step();
            cnt++;
            if (rv[1] !== 1'b0 || rv[2] !== 1'b0) saw_rsp = 1'b1;
        end
        check({tag, ".init_cycles"}, 32'(cnt), 32'd64);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s.L%0d.ready", tag, d + 1), 32'(rdy[d]), 32'd1);
            check($sformatf("%s.L%0d.init_done", tag, d + 1), 32'(idone[d]), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] burst [4];
        logic        saw;

        burst[0] = 32'hC0FF_EE00;
        burst[1] = 32'h0BAD_F00D;
        burst[2] = 32'h5A5A_5A5A;
        burst[3] = 32'h7654_3210;

        n_rst     = 1'b0;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        saw       = 1'b0;

        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst.L%0d.ready", d + 1), 32'(rdy[d]), 32'd0);
            check($sformatf("rst.L%0d.init_done", d + 1), 32'(idone[d]), 32'd0);
            check($sformatf("rst.L%0d.valid", d + 1), 32'(rv[d]), 32'd0);
            check($sformatf("rst.L%0d.rdata", d + 1), rd[d], 32'd0);
            check($sformatf("rst.L%0d.err", d + 1), 32'(re[d]), 32'd0);
        end

        measure_init("init", saw);

        // Cleared contents at first, middle and last word.
        read_one("clr_w0", 32'h0000_0000, 32'h0, 1'b0);
        read_one("clr_w31", 32'h0000_007C, 32'h0, 1'b0);
        read_one("clr_w63", 32'h0000_00FC, 32'h0, 1'b0);

        // Byte enables; 0x12 is misaligned and lands on the same word as 0x10.
        wr(32'h10, 32'hAABB_CCDD, 4'b1111);
        wr(32'h12, 32'h1122_3344, 4'b0101);
        read_one("be_merge", 32'h10, 32'hAA22_CC44, 1'b0);
        wr(32'h10, 32'hFFFF_FFFF, 4'b0000);
        read_one("be_none", 32'h10, 32'hAA22_CC44, 1'b0);

        // Out of range: no write side effect, error response, no address wrap.
        wr(32'h100, 32'hDEAD_BEEF, 4'b1111);
        read_one("oor_0x100", 32'h100, 32'h0, 1'b1);
        read_one("oor_low_ok", 32'h0, 32'h0, 1'b0);
        read_one("oor_wrap", 32'h8000_0010, 32'h0, 1'b1);
        read_one("oor_hi_ok", 32'h10, 32'hAA22_CC44, 1'b0);

        // Write followed immediately by a read of the same word.
        wr(32'h20, 32'h1234_5678, 4'b1111);
        read_one("wr_then_rd", 32'h20, 32'h1234_5678, 1'b0);

        // Four back-to-back reads; dut d strobes on cycles d..d+3.
        for (int k = 0; k < 4; k++) wr(32'h40 + 32'(4 * k), burst[k], 4'b1111);
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                req_valid = 1'b1;
                req_wen   = 1'b0;
                req_addr  = 32'h40 + 32'(4 * c);
            end else begin
                req_valid = 1'b0;
            end
            step();
            for (int d = 0; d < 3; d++) begin
                check($sformatf("burst.L%0d.c%0d.valid", d + 1, c), 32'(rv[d]),
                      32'(c >= d && c <= d + 3));
                if (c >= d && c <= d + 3) begin
                    check($sformatf("burst.L%0d.c%0d.rdata", d + 1, c), rd[d], burst[c - d]);
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("burst.L%0d.hold", d + 1), rd[d], burst[3]);
        end

        // Reset one cycle after a read accept: the pending response is dropped.
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h40;
        step();
        req_valid = 1'b0;
        n_rst     = 1'b0;
        step();
        if (rv[1] !== 1'b0 || rv[2] !== 1'b0) saw = 1'b1;
        step();
        if (rv[1] !== 1'b0 || rv[2] !== 1'b0) saw = 1'b1;
        measure_init("reinit", saw);
        repeat (4) begin
            step();
            if (rv[1] !== 1'b0 || rv[2] !== 1'b0) saw = 1'b1;
        end
        check("reset_drop.no_rsp", 32'(saw), 32'd0);

        // Reinit swept the array again.
        read_one("reclr_w4", 32'h10, 32'h0, 1'b0);
        read_one("reclr_w16", 32'h40, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dyt_sram_ctrl.md
Name: dyt_sram_ctrl

Overview:
Parametrised single-port SRAM block with a valid/ready request channel, byte-enable writes, a configurable fixed-latency read pipeline and out-of-range error signalling. It optionally clears the whole array after reset. It replaces fixed-size, address-wrapping SRAM wrappers as the memory backing for fetch and load/store paths. Storage is an inferred behavioural array; no vendor macro is used.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
DEPTH, 64, number of words; must be at least 2.
READ_LATENCY, 1, cycles from request acceptance to read response; legal range 1..4.
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests.
BYTE_ADDR, 1, 1 = req_addr is a byte address (word index = req_addr >> log2(DATA_WIDTH/8)); 0 = req_addr is a word index.

Ports:
clk  in  1  clock; all logic on the rising edge
n_rst  in  1  reset; synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_wen  in  1  1 = write, 0 = read
req_addr  in  32  byte or word address (see BYTE_ADDR)
req_wdata  in  DATA_WIDTH  write data
req_be  in  DATA_WIDTH/8  byte enables for writes; ignored for reads
rsp_valid  out  1  one-cycle read response strobe
rsp_rdata  out  DATA_WIDTH  read data
rsp_err  out  1  qualifies rsp_valid: address was out of range
init_done  out  1  array is usable; high from end of INIT until next reset

Behaviour:
- Reset: on any rising edge with n_rst=0:
  - req_ready, rsp_valid, rsp_rdata, rsp_err and init_done are all 0.
  - Read pipeline valids are cleared. In-flight reads are dropped and produce no response.
  - The clear counter is set to 0.
  - State becomes INIT if CLEAR_ON_RESET=1, otherwise READY.
- FSM states: INIT, READY.
  - INIT: writes zero to word clear_cnt each cycle; clear_cnt increments from 0.
  - INIT -> READY on the cycle that writes word DEPTH-1. INIT therefore lasts exactly DEPTH cycles.
  - In INIT, req_ready=0 and init_done=0.
  - READY: req_ready=1 and init_done=1. READY is held until reset.
  - With CLEAR_ON_RESET=0, READY is entered directly and contents are undefined.
- req_ready is a function of state only. It never depends on req_valid.
- Accept: a request is accepted on an edge where req_valid and req_ready are both 1. One request is accepted per cycle, fully pipelined.
- Word index: taken from req_addr per BYTE_ADDR.
  - Byte offset bits are ignored; misaligned addresses are treated as aligned.
  - The index is in range iff word index < DEPTH. All 32 address bits are compared; there is no wrap or modulo.
- Write: on the accept edge, each byte b with req_be[b]=1 is updated. Other bytes are unchanged.
  - req_be of all zeros is a no-op.
  - Writes produce no response.
  - An out-of-range write is dropped silently.
- Read: the array is sampled on the accept edge, so a read accepted the cycle after a write to the same word returns the new data.
  - rsp_valid is high for exactly one cycle, READ_LATENCY cycles after the accept cycle. With READ_LATENCY=1 it is the next cycle.
  - rsp_rdata and rsp_err update only when rsp_valid=1. Otherwise they hold their last values.
- Out-of-range read: produces rsp_valid=1, rsp_err=1, rsp_rdata=0 with normal latency.
- Back-to-back reads produce back-to-back responses in request order. There is no response backpressure; consumers must always sink responses.
- Mixed traffic: a write accepted between two reads does not disturb the read pipeline timing.
- Reset mid-operation: partial INIT is restarted from word 0. Pending responses are discarded.

Test Plan:
- Reset, DEPTH=64, CLEAR_ON_RESET=1:
  - req_ready and init_done stay 0 for exactly 64 cycles after n_rst rises, then go to 1.
  - Reads of words 0, 31 and 63 return 0 with rsp_err=0.
- Byte-enable write, DATA_WIDTH=32, BYTE_ADDR=1:
  - Write 0xAABBCCDD at 0x10 with be=4'b1111, then write 0x11223344 at 0x12 with be=4'b0101.
  - A read of 0x10 returns 0xAA22CC44.
- READ_LATENCY=3, four reads accepted on consecutive cycles:
  - rsp_valid is high on the four consecutive cycles starting 3 cycles after the first accept.
  - Data are returned in order. rsp_rdata holds the last value afterwards.
- Range check, DEPTH=64, BYTE_ADDR=1:
  - Write 0xDEADBEEF to 0x100 (word 64); a read of 0x100 returns rsp_err=1, rsp_rdata=0.
  - A read of 0x0 is unaffected and returns rsp_err=0.
- Write then read of the same word on consecutive cycles returns the new data.
- Reset mid-read:
  - Assert n_rst=0 one cycle after a read accept with READ_LATENCY=2: no rsp_valid ever appears for it.
  - With CLEAR_ON_RESET=1, INIT restarts and again lasts 64 cycles.
